operand_fetch: RTL and testbench

Pipeline stage directly upstream of the register file's consumers and downstream of decode. It drives the register file read addresses, merges same-cycle writeback data into the read operands, and tracks in-flight destination registers in a scoreboard so that RAW and WAW hazards stall. It registers the resolved operands into a valid/ready pipeline register that feeds execute.

---
 rtl/core_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 42 ++++
 rtl/operand_fetch.sv | 113 +++++++++++
 tb/tb_operand_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: data/register widths and the operand-fetch output entry.
package core_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    reg_idx_t        rd;
    logic            we;
  } of_entry_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one bit per register, x0 never pending.
// Busy queries see a same-cycle writeback clear so a hazard releases without a bubble.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] qa_idx,
  output logic                  qa_busy,
  input  logic [REG_ADDR_W-1:0] qb_idx,
  output logic                  qb_busy,
  input  logic [REG_ADDR_W-1:0] qc_idx,
  output logic                  qc_busy
);
  localparam int NREGS = 1 << REG_ADDR_W;

  logic [NREGS-1:0] pending_p0;
  logic [NREGS-1:0] pending_nxt;

  // Set is applied after clear so a departing entry wins over a same-index writeback.
  always_comb begin
    pending_nxt = pending_p0;
    if (clr_en) pending_nxt[clr_idx] = 1'b0;
    if (set_en) pending_nxt[set_idx] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_p0 <= '0;
    else        pending_p0 <= pending_nxt;
  end

  assign qa_busy = pending_p0[qa_idx] & ~(clr_en & (clr_idx == qa_idx));
  assign qb_busy = pending_p0[qb_idx] & ~(clr_en & (clr_idx == qb_idx));
  assign qc_busy = pending_p0[qc_idx] & ~(clr_en & (clr_idx == qc_idx));
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read with writeback bypass, RAW/WAW stall via
// scoreboard, and a valid/ready output register feeding execute.
module operand_fetch
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_we,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]       rf_rd1,
  input  logic [XLEN-1:0]       rf_rd2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic [XLEN-1:0]       wb_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_rs1_val,
  output logic [XLEN-1:0]       out_rs2_val,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_we
);
  of_entry_t entry_p1;
  logic      vld_p1;

  logic busy_rs1, busy_rs2, busy_rd;
  logic held_rs1, held_rs2, held_rd;
  logic blk_rs1, blk_rs2, blk_waw;
  logic accept, sb_set;

  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [XLEN-1:0]       rf_val,
    input logic                  byp_we,
    input logic [REG_ADDR_W-1:0] byp_addr,
    input logic [XLEN-1:0]       byp_data
  );
    if (idx == '0)                       return '0;
    else if (byp_we && byp_addr == idx)  return byp_data;
    else                                 return rf_val;
  endfunction

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // A flushed entry never reaches execute, so it must not mark its destination pending.
  assign sb_set = vld_p1 & out_ready & entry_p1.we & (entry_p1.rd != '0) & ~flush;

  reg_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (sb_set),
    .set_idx (entry_p1.rd),
    .clr_en  (wb_we),
    .clr_idx (wb_waddr),
    .qa_idx  (in_rs1),
    .qa_busy (busy_rs1),
    .qb_idx  (in_rs2),
    .qb_busy (busy_rs2),
    .qc_idx  (in_rd),
    .qc_busy (busy_rd)
  );

  assign held_rs1 = vld_p1 & entry_p1.we & (entry_p1.rd == in_rs1);
  assign held_rs2 = vld_p1 & entry_p1.we & (entry_p1.rd == in_rs2);
  assign held_rd  = vld_p1 & entry_p1.we & (entry_p1.rd == in_rd);

  assign blk_rs1 = in_use_rs1 & (in_rs1 != '0) & (busy_rs1 | held_rs1);
  assign blk_rs2 = in_use_rs2 & (in_rs2 != '0) & (busy_rs2 | held_rs2);
  assign blk_waw = in_we & (in_rd != '0) & (busy_rd | held_rd);

  assign in_ready = ~(blk_rs1 | blk_rs2 | blk_waw) & (~vld_p1 | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  // Stage boundary: resolved operands into the execute-facing register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      entry_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1           <= 1'b1;
      entry_p1.pc      <= in_pc;
      entry_p1.rs1_val <= resolve(in_rs1, rf_rd1, wb_we, wb_waddr, wb_wdata);
      entry_p1.rs2_val <= resolve(in_rs2, rf_rd2, wb_we, wb_waddr, wb_wdata);
      entry_p1.rd      <= in_rd;
      entry_p1.we      <= in_we;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = entry_p1.pc;
  assign out_rs1_val = entry_p1.rs1_val;
  assign out_rs2_val = entry_p1.rs2_val;
  assign out_rd      = entry_p1.rd;
  assign out_we      = entry_p1.we;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table for forwarding, hand sequences for hazards.
module tb_operand_fetch;
  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_we;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid, out_ready, out_we;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_we(in_we),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_we(out_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x0 is an ordinary storage location here.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + i;
    end else if (wb_we) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end
  assign rf_rd1 = rf[rf_raddr1];
  assign rf_rd2 = rf[rf_raddr2];

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        use1, use2, wbe;
    logic [4:0]  wba;
    logic [31:0] wbd, e1, e2;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_we = 0; in_rd = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rs1 = 0; in_rs2 = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0; flush = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h1000_0001, 32'h1000_0002};
    vecs[1] = '{5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         32'h1000_0003};
    vecs[2] = '{5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 32'hCAFEF00D,  32'hCAFEF00D};
    vecs[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h0000_0055, 32'h0,        32'h0};
    vecs[4] = '{5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         32'hCAFEF00D};
    vecs[5] = '{5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1234_5678, 32'h1000_0007, 32'h1234_5678};
    vecs[6] = '{5'd6, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0,        32'h1234_5678, 32'h0};

    idle();
    rst_n = 0; out_ready = 1; in_pc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_rs1", out_rs1_val, 32'h0);
    chk("rst_rs2", out_rs2_val, 32'h0);
    chk("rst_rd_we", {26'b0, out_rd, out_we}, 32'h0);
    rst_n = 1;
    tick();

    // Back-to-back forwarding vectors, one accept per cycle.
    for (int i = 0; i < 7; i++) begin
      idle();
      in_valid = 1; in_pc = 32'h100 + 4 * i;
      in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
      in_use_rs1 = vecs[i].use1; in_use_rs2 = vecs[i].use2;
      wb_we = vecs[i].wbe; wb_waddr = vecs[i].wba; wb_wdata = vecs[i].wbd;
      #1;
      chk($sformatf("v%0d_ready", i), {31'b0, in_ready}, 32'h1);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h100 + 4 * i);
      chk($sformatf("v%0d_rs1", i), out_rs1_val, vecs[i].e1);
      chk($sformatf("v%0d_rs2", i), out_rs2_val, vecs[i].e2);
    end
    idle();
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'h0);

    // RAW on x5: held entry, then pending, released by writeback bypass.
    idle(); in_valid = 1; in_we = 1; in_rd = 5; in_pc = 32'h200;
    #1 chk("A_issue_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("A_out_rd_we", {26'b0, out_rd, out_we}, {26'b0, 5'd5, 1'b1});
    idle(); in_rs1 = 5; in_use_rs1 = 1;
    #1 chk("A_held_stall", {31'b0, in_ready}, 32'h0);
    tick();
    chk("A_departed", {31'b0, out_valid}, 32'h0);
    chk("A_pend_stall", {31'b0, in_ready}, 32'h0);
    tick();
    chk("A_pend_stall2", {31'b0, in_ready}, 32'h0);
    wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF; in_valid = 1; in_pc = 32'h204;
    #1 chk("A_wb_release", {31'b0, in_ready}, 32'h1);
    tick();
    idle();
    chk("A_valid", {31'b0, out_valid}, 32'h1);
    chk("A_rs1_fwd", out_rs1_val, 32'hDEADBEEF);
    tick();

    // RAW on x7 against an entry held by out_ready=0.
    out_ready = 0;
    idle(); in_valid = 1; in_we = 1; in_rd = 7; in_pc = 32'h300;
    #1 chk("B_issue_ready", {31'b0, in_ready}, 32'h1);
    tick();
    idle(); in_valid = 1; in_rs2 = 7; in_use_rs2 = 1; in_pc = 32'h304;
    #1 chk("B_held_stall", {31'b0, in_ready}, 32'h0);
    tick();
    chk("B_hold_pc", out_pc, 32'h300);
    chk("B_hold_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1;
    #1 chk("B_depart_stall", {31'b0, in_ready}, 32'h0);
    tick();
    chk("B_gone", {31'b0, out_valid}, 32'h0);
    chk("B_pend_stall", {31'b0, in_ready}, 32'h0);
    wb_we = 1; wb_waddr = 7; wb_wdata = 32'hA5A5A5A5;
    #1 chk("B_wb_release", {31'b0, in_ready}, 32'h1);
    tick();
    idle();
    chk("B_pc", out_pc, 32'h304);
    chk("B_rs2_fwd", out_rs2_val, 32'hA5A5A5A5);
    tick();

    // Set and clear of x3 in the same cycle: set wins.
    idle(); in_valid = 1; in_we = 1; in_rd = 3; in_pc = 32'h400;
    tick();
    idle(); wb_we = 1; wb_waddr = 3; wb_wdata = 32'h33;
    tick();
    idle(); in_rs1 = 3; in_use_rs1 = 1;
    #1 chk("C_set_wins", {31'b0, in_ready}, 32'h0);
    wb_we = 1; wb_waddr = 3; wb_wdata = 32'h44;
    #1 chk("C_wb_release", {31'b0, in_ready}, 32'h1);
    tick();
    wb_we = 0;
    #1 chk("C_cleared", {31'b0, in_ready}, 32'h1);

    // Flush of a held rd=9 entry.
    idle(); in_valid = 1; in_we = 1; in_rd = 9; in_pc = 32'h500;
    tick();
    chk("D_held", {26'b0, out_rd, out_we}, {26'b0, 5'd9, 1'b1});
    idle(); flush = 1; in_valid = 1; in_pc = 32'h4FF;
    #1 chk("D_flush_blocks", {31'b0, in_ready}, 32'h0);
    tick();
    idle();
    chk("D_flushed", {31'b0, out_valid}, 32'h0);
    in_rs1 = 9; in_use_rs1 = 1;
    #1 chk("D_no_pend", {31'b0, in_ready}, 32'h1);

    // WAW on x10.
    idle(); in_valid = 1; in_we = 1; in_rd = 10; in_pc = 32'h600;
    tick();
    out_ready = 0; in_pc = 32'h604;
    #1 chk("E_waw_held", {31'b0, in_ready}, 32'h0);
    out_ready = 1;
    #1 chk("E_waw_depart", {31'b0, in_ready}, 32'h0);
    tick();
    chk("E_waw_pend", {31'b0, in_ready}, 32'h0);
    wb_we = 1; wb_waddr = 10; wb_wdata = 32'h0;
    #1 chk("E_waw_release", {31'b0, in_ready}, 32'h1);
    tick();
    idle();
    chk("E_out_pc", out_pc, 32'h604);
    tick();

    // Asynchronous reset discards pending x10.
    idle(); in_rs1 = 10; in_use_rs1 = 1;
    #1 chk("F_pend_before", {31'b0, in_ready}, 32'h0);
    wb_we = 1; wb_waddr = 10;
    rst_n = 0;
    #1;
    chk("F_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("F_rst_pc", out_pc, 32'h0);
    wb_we = 0;
    #1 chk("F_rst_pend", {31'b0, in_ready}, 32'h1);
    tick();
    rst_n = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
